// File: rtl/mmio_uart_tx_if.sv
// CPU data-port bundle seen by the MMIO console transmitter.
// The CPU is the master; the UART is the responder that decodes the window and returns load data.
interface mmio_uart_tx_if;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  funct3;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output mem_write,
        output mem_addr,
        output mem_wdata,
        output funct3,
        input  sel,
        input  rdata
    );

    modport slave (
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        input  funct3,
        output sel,
        output rdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter: TXDATA stores fill a byte FIFO that a
// serializer drains LSB first; STATUS and BAUD_DIV let firmware poll and pace output.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR        = 32'h1000_0000,
    parameter int          ADDR_SPAN        = 1024,
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd868
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           tx_active
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    logic [32:0] addr_ext;
    logic [32:0] win_lo;
    logic [32:0] win_hi;
    logic [31:0] offset;
    logic        is_txdata;
    logic        is_status;
    logic        is_baud;

    logic        push_req;
    logic        push_ok;
    logic        drop;
    logic        pop;
    logic        status_wr;
    logic        baud_wr;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;

    logic        overflow;
    logic [15:0] baud_div;
    logic [15:0] eff_div;

    logic [31:0] reg_val;
    logic [31:0] read_ext;
    logic [31:0] status_val;

    tx_state_t   state;
    tx_state_t   next_state;
    logic [15:0] tick_cnt;
    logic [15:0] div_lat;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        seg_done;

    logic        unused_bits;

    // Widened by one bit so a window ending at the top of the address space cannot wrap.
    assign addr_ext = {1'b0, bus.mem_addr};
    assign win_lo   = {1'b0, BASE_ADDR};
    assign win_hi   = {1'b0, BASE_ADDR} + 33'(ADDR_SPAN);
    assign bus.sel  = (addr_ext >= win_lo) && (addr_ext < win_hi);

    assign offset    = bus.mem_addr - BASE_ADDR;
    assign is_txdata = (offset[31:2] == 30'd0);
    assign is_status = (offset[31:2] == 30'd1);
    assign is_baud   = (offset[31:2] == 30'd2);

    assign unused_bits = ^{offset[1:0], bus.mem_wdata[31:16]};

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    assign push_req  = bus.mem_write & bus.sel & is_txdata;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign drop      = push_req & fifo_full & ~pop;
    assign status_wr = bus.mem_write & bus.sel & is_status;
    assign baud_wr   = bus.mem_write & bus.sel & is_baud &
                       ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010));

    assign eff_div  = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign seg_done = (tick_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A drop and a W1C in the same cycle leave the flag set so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_wr && bus.mem_wdata[3]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            baud_div <= DEFAULT_BAUD_DIV;
        end else if (baud_wr) begin
            baud_div <= bus.mem_wdata[15:0];
        end
    end

    assign status_val = {16'h0000, 8'(fifo_count), 4'h0,
                         overflow, fifo_empty, fifo_full, tx_active};

    always_comb begin
        reg_val = 32'h0;
        if (is_status) begin
            reg_val = status_val;
        end else if (is_baud) begin
            reg_val = {16'h0000, baud_div};
        end
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  read_ext = {{24{reg_val[7]}}, reg_val[7:0]};
            3'b001:  read_ext = {{16{reg_val[15]}}, reg_val[15:0]};
            3'b100:  read_ext = {24'h0, reg_val[7:0]};
            3'b101:  read_ext = {16'h0, reg_val[15:0]};
            default: read_ext = reg_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.rdata <= 32'h0;
        end else if (bus.sel) begin
            bus.rdata <= read_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = START;
                end
            end
            START: begin
                if (seg_done) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (seg_done && (bit_idx == 3'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (seg_done) begin
                    next_state = fifo_empty ? IDLE : START;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Popping at the end of STOP chains frames with no idle gap.
    always_comb begin
        pop       = 1'b0;
        txd       = 1'b1;
        tx_active = 1'b0;
        case (state)
            IDLE: begin
                pop = ~fifo_empty;
            end
            START: begin
                txd       = 1'b0;
                tx_active = 1'b1;
            end
            DATA: begin
                txd       = shreg[0];
                tx_active = 1'b1;
            end
            STOP: begin
                tx_active = 1'b1;
                pop       = seg_done & ~fifo_empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // The divider is captured with the byte so BAUD_DIV writes only affect later frames.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= 16'd0;
            div_lat  <= 16'd1;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
        end else if (pop) begin
            shreg    <= fifo_head;
            div_lat  <= eff_div;
            tick_cnt <= eff_div - 16'd1;
            bit_idx  <= 3'd0;
        end else if (state != IDLE) begin
            if (seg_done) begin
                tick_cnt <= div_lat - 16'd1;
                if (state == DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                tick_cnt <= tick_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: bus accesses plus a line model that predicts
// txd cycle by cycle from the queued bytes and their dividers.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam int          SPAN       = 1024;
    localparam int          DEPTH      = 16;
    localparam logic [15:0] DEF_DIV    = 16'd868;
    localparam logic [31:0] A_TXDATA   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS   = BASE + 32'h4;
    localparam logic [31:0] A_BAUD     = BASE + 32'h8;
    localparam logic [2:0]  F_B        = 3'b000;
    localparam logic [2:0]  F_H        = 3'b001;
    localparam logic [2:0]  F_W        = 3'b010;
    localparam logic [2:0]  F_BU       = 3'b100;
    localparam logic [2:0]  F_HU       = 3'b101;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic txd;
    logic tx_active;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_bytes [$];
    int         exp_divs  [$];

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .BASE_ADDR        (BASE),
        .ADDR_SPAN        (SPAN),
        .FIFO_DEPTH       (DEPTH),
        .DEFAULT_BAUD_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .txd       (txd),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic exp_bit(input logic [7:0] b, input int d, input int k);
        int seg;
        seg = k / d;
        if (seg == 0) return 1'b0;
        if (seg >= 9) return 1'b1;
        return b[seg-1];
    endfunction

    function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit act);
        return (32'(cnt) << 8) | {28'h0, ovf, (cnt == 0), (cnt == DEPTH), act};
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        bus_if.mem_write = 1'b1;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = data;
        bus_if.funct3    = f3;
        @(negedge clk);
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [2:0] f3, output logic [31:0] data);
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr  = addr;
        bus_if.funct3    = f3;
        @(negedge clk);
        data = bus_if.rdata;
        bus_if.mem_addr  = 32'h0;
    endtask

    // Expects txd idle for 'lead' samples, then every queued frame back to back, then idle.
    task automatic watch_line(input int lead);
        logic [7:0] b;
        int d;
        logic e;
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            total++;
            if (txd !== 1'b1) begin
                bad++;
                $display("[TB] FAIL lead_idle: got %b expected 1", txd);
            end
        end
        while (exp_bytes.size() > 0) begin
            b = exp_bytes.pop_front();
            d = exp_divs.pop_front();
            for (int k = 0; k < 10 * d; k++) begin
                @(negedge clk);
                e = exp_bit(b, d, k);
                total++;
                if (txd !== e || tx_active !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL frame_%02h_k%0d: got txd=%b act=%b expected txd=%b act=1",
                             b, k, txd, tx_active, e);
                end
            end
        end
        @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_active !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_idle: got txd=%b act=%b expected txd=1 act=0", txd, tx_active);
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.funct3    = F_W;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_active !== 1'b0 || bus_if.rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL in_reset: got txd=%b act=%b rdata=%h expected 1 0 0",
                     txd, tx_active, bus_if.rdata);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_active !== 1'b0) begin
            bad++;
            $display("[TB] FAIL after_release: got txd=%b act=%b expected 1 0", txd, tx_active);
        end
        bus_read(A_STATUS, F_W, r);
        total++;
        if (r !== 32'h0000_0004) begin
            bad++;
            $display("[TB] FAIL reset_status: got %h expected 00000004", r);
        end
        bus_read(A_BAUD, F_W, r);
        total++;
        if (r !== {16'h0, DEF_DIV}) begin
            bad++;
            $display("[TB] FAIL reset_baud: got %h expected %h", r, {16'h0, DEF_DIV});
        end
    endtask

    task automatic test_window_and_regs;
        logic [31:0] a;
        logic [31:0] r;
        logic        e;
        logic [31:0] edges [4];
        edges[0] = BASE - 32'd1;
        edges[1] = BASE;
        edges[2] = BASE + 32'(SPAN) - 32'd1;
        edges[3] = BASE + 32'(SPAN);
        for (int i = 0; i < 12; i++) begin
            a = (i < 4) ? edges[i] : (BASE - 32'd2048 + 32'($urandom_range(0, 4095)));
            e = (a >= BASE) && (a < BASE + 32'(SPAN));
            bus_if.mem_addr = a;
            #1;
            total++;
            if (bus_if.sel !== e) begin
                bad++;
                $display("[TB] FAIL sel_%h: got %b expected %b", a, bus_if.sel, e);
            end
        end
        bus_if.mem_addr = 32'h0;
        @(negedge clk);
        bus_read(A_TXDATA, F_W, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("[TB] FAIL txdata_reads_zero: got %h expected 0", r);
        end
        a = BASE + (32'($urandom_range(3, 255)) << 2);
        bus_write(a, 32'hFFFF_FFFF, F_W);
        bus_read(a, F_W, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("[TB] FAIL unmapped_read: got %h expected 0", r);
        end
        bus_read(A_BAUD, F_W, r);
        repeat (3) @(negedge clk);
        total++;
        if (r !== {16'h0, DEF_DIV} || bus_if.rdata !== {16'h0, DEF_DIV}) begin
            bad++;
            $display("[TB] FAIL rdata_hold: got %h/%h expected %h", r, bus_if.rdata, {16'h0, DEF_DIV});
        end
    endtask

    task automatic test_single_frame;
        bus_write(A_BAUD, 32'd4, F_W);
        exp_bytes.push_back(8'h55);
        exp_divs.push_back(4);
        fork
            bus_write(A_TXDATA, 32'hDEAD_BE55, F_W);
            watch_line(1);
        join
    endtask

    task automatic test_back_to_back;
        bus_write(A_BAUD, 32'd2, F_W);
        exp_bytes.push_back(8'h41);
        exp_divs.push_back(2);
        exp_bytes.push_back(8'h42);
        exp_divs.push_back(2);
        fork
            begin
                bus_write(A_TXDATA, 32'h41, F_B);
                bus_write(A_TXDATA, 32'h42, F_B);
            end
            watch_line(1);
        join
    endtask

    task automatic test_baud_latch;
        bus_write(A_BAUD, 32'd2, F_W);
        exp_bytes.push_back(8'hC3);
        exp_divs.push_back(2);
        exp_bytes.push_back(8'h1E);
        exp_divs.push_back(3);
        fork
            begin
                bus_write(A_TXDATA, 32'hC3, F_W);
                bus_write(A_TXDATA, 32'h1E, F_W);
                bus_write(A_BAUD, 32'd3, F_H);
            end
            watch_line(1);
        join
    endtask

    task automatic test_extension;
        logic [31:0] r;
        logic [31:0] v;
        logic [2:0]  f3s  [5];
        logic [31:0] exps [5];
        v = 32'h0000_80F0;
        f3s[0] = F_B;  exps[0] = {{24{v[7]}}, v[7:0]};
        f3s[1] = F_BU; exps[1] = {24'h0, v[7:0]};
        f3s[2] = F_H;  exps[2] = {{16{v[15]}}, v[15:0]};
        f3s[3] = F_HU; exps[3] = {16'h0, v[15:0]};
        f3s[4] = F_W;  exps[4] = v;
        bus_write(A_BAUD, 32'h1234_80F0, F_W);
        for (int i = 0; i < 5; i++) begin
            bus_read(A_BAUD, f3s[i], r);
            total++;
            if (r !== exps[i]) begin
                bad++;
                $display("[TB] FAIL ext_f3_%0d: got %h expected %h", f3s[i], r, exps[i]);
            end
        end
        bus_write(A_BAUD, 32'h0000_0012, F_B);
        bus_read(A_BAUD, F_W, r);
        total++;
        if (r !== v) begin
            bad++;
            $display("[TB] FAIL sb_baud_ignored: got %h expected %h", r, v);
        end
        bus_write(A_BAUD, 32'hABCD_0000, F_H);
        bus_read(A_BAUD, F_W, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("[TB] FAIL sh_baud_zero: got %h expected 0", r);
        end
        exp_bytes.push_back(8'hB2);
        exp_divs.push_back(1);
        fork
            bus_write(A_TXDATA, 32'hB2, F_W);
            watch_line(1);
        join
    endtask

    task automatic test_random;
        int d;
        int n;
        logic [7:0] b;
        logic [7:0] bl [$];
        for (int it = 0; it < 5; it++) begin
            d = $urandom_range(0, 5);
            n = $urandom_range(1, 4);
            bus_write(A_BAUD, 32'(d), F_W);
            bl.delete();
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                bl.push_back(b);
                exp_bytes.push_back(b);
                exp_divs.push_back((d == 0) ? 1 : d);
            end
            fork
                begin
                    for (int j = 0; j < n; j++) begin
                        bus_write(A_TXDATA, {24'($urandom), bl[j]}, F_B);
                    end
                end
                watch_line(1);
            join
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        int npush;
        int cnt;
        bit ovf;
        npush = DEPTH + 2;
        bus_write(A_BAUD, 32'h0000_FFFF, F_W);
        for (int i = 0; i < npush; i++) begin
            bus_if.mem_write = 1'b1;
            bus_if.mem_addr  = A_TXDATA;
            bus_if.mem_wdata = 32'($urandom);
            bus_if.funct3    = F_W;
            @(negedge clk);
        end
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr  = 32'h0;
        cnt = (npush - 1 > DEPTH) ? DEPTH : npush - 1;
        ovf = (npush - 1 > DEPTH);
        bus_read(A_STATUS, F_W, r);
        total++;
        if (r !== status_word(cnt, ovf, 1'b1)) begin
            bad++;
            $display("[TB] FAIL full_status: got %h expected %h", r, status_word(cnt, ovf, 1'b1));
        end
        bus_read(A_STATUS, F_B, r);
        total++;
        if (r !== {24'h0, status_word(cnt, ovf, 1'b1) & 32'hFF}) begin
            bad++;
            $display("[TB] FAIL lb_status: got %h expected %h", r, status_word(cnt, ovf, 1'b1) & 32'hFF);
        end
        bus_read(A_STATUS, F_HU, r);
        total++;
        if (r !== (status_word(cnt, ovf, 1'b1) & 32'hFFFF)) begin
            bad++;
            $display("[TB] FAIL lhu_status: got %h expected %h", r, status_word(cnt, ovf, 1'b1) & 32'hFFFF);
        end
        bus_write(A_STATUS, 32'h0000_0007, F_W);
        bus_read(A_STATUS, F_W, r);
        total++;
        if (r !== status_word(cnt, ovf, 1'b1)) begin
            bad++;
            $display("[TB] FAIL ovf_kept: got %h expected %h", r, status_word(cnt, ovf, 1'b1));
        end
        bus_write(A_STATUS, 32'h0000_0008, F_W);
        bus_read(A_STATUS, F_W, r);
        total++;
        if (r !== status_word(cnt, 1'b0, 1'b1)) begin
            bad++;
            $display("[TB] FAIL ovf_w1c: got %h expected %h", r, status_word(cnt, 1'b0, 1'b1));
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_STATUS, F_W, r);
        total++;
        if (r !== status_word(0, 1'b0, 1'b0)) begin
            bad++;
            $display("[TB] FAIL status_after_reset: got %h expected %h", r, status_word(0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] r;
        logic [7:0] first;
        first = 8'hA5;
        bus_write(A_BAUD, 32'd4, F_W);
        bus_write(A_TXDATA, 32'(first), F_W);
        bus_write(A_TXDATA, 32'h3C, F_W);
        bus_write(A_TXDATA, 32'h7E, F_W);
        bus_read(A_STATUS, F_W, r);
        total++;
        if (r !== status_word(2, 1'b0, 1'b1)) begin
            bad++;
            $display("[TB] FAIL pre_reset_status: got %h expected %h", r, status_word(2, 1'b0, 1'b1));
        end
        repeat (15) @(negedge clk);
        total++;
        if (txd !== exp_bit(first, 4, 17) || tx_active !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_bit3: got txd=%b act=%b expected txd=%b act=1",
                     txd, tx_active, exp_bit(first, 4, 17));
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_active !== 1'b0 || bus_if.rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL abort_frame: got txd=%b act=%b rdata=%h expected 1 0 0",
                     txd, tx_active, bus_if.rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_STATUS, F_W, r);
        total++;
        if (r !== status_word(0, 1'b0, 1'b0)) begin
            bad++;
            $display("[TB] FAIL post_abort_status: got %h expected %h", r, status_word(0, 1'b0, 1'b0));
        end
        bus_write(A_BAUD, 32'd3, F_W);
        exp_bytes.push_back(8'h96);
        exp_divs.push_back(3);
        fork
            bus_write(A_TXDATA, 32'h96, F_W);
            watch_line(1);
        join
    endtask

    initial begin
        test_reset();
        test_window_and_regs();
        test_single_frame();
        test_back_to_back();
        test_baud_latch();
        test_extension();
        test_random();
        test_overflow();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
